multi_buffer_model: RTL and testbench

- Parametrised, clocked, N-channel behavioural model of the analog output buffer.
- Each channel drives a millivolt output code that slews toward a target at a programmable rate. The target is either the channel's input voltage or an internal sine generator.
- Target is clipped to the supply rail; a per-channel ready flag asserts once the output has settled.
- Used in simulation and FPGA emulation wherever the analog buffer macro sits, to give firmware a realistic settling and saturation response.

---
 rtl/multi_buffer_model.sv | 231 +++++++++++++++++++++++
 tb/tb_multi_buffer_model.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multi_buffer_model.sv
// N-channel behavioural model of the analog output buffer: slew-limited millivolt outputs with rail clipping and settle detect.
// Define MULTI_BUFFER_SINE_EN to add the per-channel sine target generator (phase accumulator + quarter-wave LUT).
module multi_buffer_model #(
   parameter int N_CH       = 2,
   parameter int V_W        = 12,
   parameter int VMAX_MV    = 1800,
   parameter int TOL_MV     = 2,
   parameter int SETTLE_CNT = 4,
   parameter int PHASE_W    = 16,
   parameter int OFFSET_MV  = 900,
   parameter int AMP_MV     = 500
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [N_CH-1:0]       en_i,
   input  logic [N_CH-1:0]       mode_i,
   input  logic [N_CH*V_W-1:0]   vin_mv_i,
   input  logic [V_W-1:0]        slew_mv_i,
   input  logic [PHASE_W-1:0]    freq_word_i,
   output logic [N_CH*V_W-1:0]   vout_mv_o,
   output logic [N_CH-1:0]       ready_o,
   output logic [N_CH-1:0]       sat_o
);

   localparam int            CNT_W     = $clog2(SETTLE_CNT + 1);
   localparam logic [V_W-1:0] VMAX_C   = V_W'(VMAX_MV);
   localparam logic [V_W:0]   TOL_C    = (V_W+1)'(TOL_MV);
   localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CNT);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_TRACK  = 2'd2
   } state_e;

`ifdef MULTI_BUFFER_SINE_EN
   localparam int VCODE_MAX = (1 << V_W) - 1;

   // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64; other quadrants are folded from it.
   function automatic logic [15:0] quarter_sin(input logic [6:0] idx);
      logic [15:0] v;
      case (idx)
         7'd0:  v = 16'd0;     7'd1:  v = 16'd804;   7'd2:  v = 16'd1608;  7'd3:  v = 16'd2410;
         7'd4:  v = 16'd3212;  7'd5:  v = 16'd4011;  7'd6:  v = 16'd4808;  7'd7:  v = 16'd5602;
         7'd8:  v = 16'd6393;  7'd9:  v = 16'd7179;  7'd10: v = 16'd7962;  7'd11: v = 16'd8739;
         7'd12: v = 16'd9512;  7'd13: v = 16'd10278; 7'd14: v = 16'd11039; 7'd15: v = 16'd11793;
         7'd16: v = 16'd12539; 7'd17: v = 16'd13279; 7'd18: v = 16'd14010; 7'd19: v = 16'd14732;
         7'd20: v = 16'd15446; 7'd21: v = 16'd16151; 7'd22: v = 16'd16846; 7'd23: v = 16'd17530;
         7'd24: v = 16'd18204; 7'd25: v = 16'd18868; 7'd26: v = 16'd19519; 7'd27: v = 16'd20159;
         7'd28: v = 16'd20787; 7'd29: v = 16'd21403; 7'd30: v = 16'd22005; 7'd31: v = 16'd22594;
         7'd32: v = 16'd23170; 7'd33: v = 16'd23731; 7'd34: v = 16'd24279; 7'd35: v = 16'd24811;
         7'd36: v = 16'd25329; 7'd37: v = 16'd25832; 7'd38: v = 16'd26319; 7'd39: v = 16'd26790;
         7'd40: v = 16'd27245; 7'd41: v = 16'd27683; 7'd42: v = 16'd28105; 7'd43: v = 16'd28510;
         7'd44: v = 16'd28898; 7'd45: v = 16'd29268; 7'd46: v = 16'd29621; 7'd47: v = 16'd29956;
         7'd48: v = 16'd30273; 7'd49: v = 16'd30571; 7'd50: v = 16'd30852; 7'd51: v = 16'd31113;
         7'd52: v = 16'd31356; 7'd53: v = 16'd31580; 7'd54: v = 16'd31785; 7'd55: v = 16'd31971;
         7'd56: v = 16'd32137; 7'd57: v = 16'd32285; 7'd58: v = 16'd32412; 7'd59: v = 16'd32521;
         7'd60: v = 16'd32609; 7'd61: v = 16'd32678; 7'd62: v = 16'd32728; 7'd63: v = 16'd32757;
         7'd64: v = 16'd32767;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   // Sine sample in mV for table index k: OFFSET + floor(AMP*lut/2^15), clamped into the code range.
   function automatic logic [V_W-1:0] sine_mv(input logic [7:0] k);
      logic [15:0]        mag;
      logic signed [31:0] lut_v;
      logic signed [31:0] prod;
      logic signed [31:0] val;
      logic [V_W-1:0]     res;
      if (k[6]) begin
         mag = quarter_sin(7'd64 - {1'b0, k[5:0]});
      end else begin
         mag = quarter_sin({1'b0, k[5:0]});
      end
      if (k[7]) begin
         lut_v = -$signed({16'd0, mag});
      end else begin
         lut_v = $signed({16'd0, mag});
      end
      prod = $signed(32'(AMP_MV)) * lut_v;
      val  = $signed(32'(OFFSET_MV)) + (prod >>> 15);
      if (val < 0) begin
         res = {V_W{1'b0}};
      end else if (val > VCODE_MAX) begin
         res = {V_W{1'b1}};
      end else begin
         res = val[V_W-1:0];
      end
      return res;
   endfunction
`else
   logic unused_sine_s;
   assign unused_sine_s = ^{mode_i, freq_word_i};
`endif

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      state_e               state_q, state_d;
      logic [V_W-1:0]       vout_q, vout_d;
      logic [CNT_W-1:0]     cnt_q, cnt_d;
      logic                 ready_q, ready_d;
      logic                 sat_q, sat_d;
      logic [V_W-1:0]       vin_s, tgt_raw_s, tgt_s, vnext_s;
      logic signed [V_W:0]  diff_s, resid_s;
      logic [V_W:0]         absd_s, absr_s;
      logic                 in_tol_s;
      logic [CNT_W-1:0]     cnt_inc_s;

      assign vin_s = vin_mv_i[c*V_W +: V_W];

`ifdef MULTI_BUFFER_SINE_EN
      logic [PHASE_W-1:0] phase_q, phase_d;

      assign tgt_raw_s = mode_i[c] ? sine_mv(phase_q[PHASE_W-1 -: 8]) : vin_s;

      // Phase advances only while enabled in sine mode; disabling the channel rewinds it.
      always_comb begin
         phase_d = phase_q;
         if (!en_i[c]) begin
            phase_d = {PHASE_W{1'b0}};
         end else if (mode_i[c]) begin
            phase_d = phase_q + freq_word_i;
         end else begin
            phase_d = phase_q;
         end
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            phase_q <= {PHASE_W{1'b0}};
         end else begin
            phase_q <= phase_d;
         end
      end
`else
      assign tgt_raw_s = vin_s;
`endif

      assign tgt_s = (tgt_raw_s > VMAX_C) ? VMAX_C : tgt_raw_s;

      // Slew-limited next output and residual error; |diff| > slew guarantees the step cannot wrap.
      always_comb begin
         diff_s = $signed({1'b0, tgt_s}) - $signed({1'b0, vout_q});
         absd_s = diff_s[V_W] ? -diff_s : diff_s;
         if ((slew_mv_i == {V_W{1'b0}}) || (absd_s <= {1'b0, slew_mv_i})) begin
            vnext_s = tgt_s;
         end else if (!diff_s[V_W]) begin
            vnext_s = vout_q + slew_mv_i;
         end else begin
            vnext_s = vout_q - slew_mv_i;
         end
         resid_s   = $signed({1'b0, tgt_s}) - $signed({1'b0, vnext_s});
         absr_s    = resid_s[V_W] ? -resid_s : resid_s;
         in_tol_s  = (absr_s <= TOL_C);
         cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      always_comb begin
         state_d = state_q;
         vout_d  = vout_q;
         cnt_d   = cnt_q;
         ready_d = ready_q;
         sat_d   = en_i[c] && (tgt_raw_s > VMAX_C);
         if (!en_i[c]) begin
            state_d = ST_OFF;
            vout_d  = {V_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            ready_d = 1'b0;
         end else begin
            case (state_q)
               ST_OFF: begin
                  state_d = ST_SETTLE;
                  vout_d  = {V_W{1'b0}};
                  cnt_d   = {CNT_W{1'b0}};
                  ready_d = 1'b0;
               end
               ST_SETTLE: begin
                  vout_d = vnext_s;
                  if (!in_tol_s) begin
                     cnt_d = {CNT_W{1'b0}};
                  end else if (cnt_inc_s == SETTLE_C) begin
                     cnt_d   = cnt_inc_s;
                     state_d = ST_TRACK;
                     ready_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc_s;
                  end
               end
               ST_TRACK: begin
                  vout_d = vnext_s;
                  if (!in_tol_s) begin
                     state_d = ST_SETTLE;
                     ready_d = 1'b0;
                     cnt_d   = {CNT_W{1'b0}};
                  end else begin
                     ready_d = 1'b1;
                  end
               end
               default: begin
                  state_d = ST_OFF;
                  vout_d  = {V_W{1'b0}};
                  cnt_d   = {CNT_W{1'b0}};
                  ready_d = 1'b0;
               end
            endcase
         end
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            state_q <= ST_OFF;
            vout_q  <= {V_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b0;
            sat_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            vout_q  <= vout_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            sat_q   <= sat_d;
         end
      end

      assign vout_mv_o[c*V_W +: V_W] = vout_q;
      assign ready_o[c]              = ready_q;
      assign sat_o[c]                = sat_q;
   end

endmodule

// File: tb/tb_multi_buffer_model.sv
// Directed self-checking bench for multi_buffer_model (default channel count and widths).
module tb_multi_buffer_model;

   logic        clk;
   logic        rst_n;
   logic [1:0]  en;
   logic [1:0]  mode;
   logic [11:0] vin0;
   logic [11:0] vin1;
   logic [11:0] slew;
   logic [15:0] freq;
   logic [23:0] vout;
   logic [1:0]  ready;
   logic [1:0]  sat;
   logic [11:0] vout0;
   logic [11:0] vout1;
   int          n_pass;
   int          n_total;

   assign vout0 = vout[11:0];
   assign vout1 = vout[23:12];

   multi_buffer_model dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .mode_i      (mode),
      .vin_mv_i    ({vin1, vin0}),
      .slew_mv_i   (slew),
      .freq_word_i (freq),
      .vout_mv_o   (vout),
      .ready_o     (ready),
      .sat_o       (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

`ifdef MULTI_BUFFER_SINE_EN
   localparam int EXP_K64  = 1399;
   localparam int EXP_K192 = 400;
   localparam int EXP_K0   = 900;
`else
   localparam int EXP_K64  = 700;
   localparam int EXP_K192 = 700;
   localparam int EXP_K0   = 700;
`endif

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n = 1'b0; en = 2'b11; mode = 2'b00;
      vin0 = 12'd1000; vin1 = 12'd0; slew = 12'd100; freq = 16'd256;

      // reset held with both channels enabled
      repeat (3) step();
      chk("rst_vout0", vout0, 0);
      chk("rst_vout1", vout1, 0);
      chk("rst_ready", ready, 0);
      chk("rst_sat", sat, 0);

      // ch0 slews to 1000 in 100 mV steps
      en = 2'b01; rst_n = 1'b1;
      step();
      chk("entry_vout0", vout0, 0);
      for (int i = 1; i <= 10; i++) begin
         step();
         chk($sformatf("slew_e%0d", i), vout0, i * 100);
      end
      chk("ready_e10", ready, 0);
      repeat (2) step();
      chk("ready_e12", ready, 0);
      step();
      chk("ready_e13", ready, 2'b01);
      chk("ch1_idle", vout1, 0);

      // small disturbance absorbed in one step keeps ready
      vin0 = 12'd1003;
      step();
      chk("dist_small_vout", vout0, 1003);
      chk("dist_small_ready", ready, 2'b01);

      // larger-than-slew disturbance drops ready, then re-settles
      vin0 = 12'd1300;
      step();
      chk("dist_big_vout", vout0, 1103);
      chk("dist_big_ready", ready, 0);
      step();
      chk("resettle_vout_a", vout0, 1203);
      step();
      chk("resettle_vout_b", vout0, 1300);
      repeat (2) step();
      chk("resettle_ready_3", ready, 0);
      step();
      chk("resettle_ready_4", ready, 2'b01);

      // rail clip with unlimited slew; disabled ch1 never flags sat
      slew = 12'd0; vin0 = 12'd2500; vin1 = 12'd3000;
      step();
      chk("clip_vout", vout0, 1800);
      chk("clip_sat", sat, 2'b01);
      chk("clip_ready", ready, 2'b01);
      vin0 = 12'd1790;
      step();
      chk("unclip_vout", vout0, 1790);
      chk("unclip_sat", sat, 0);

      // tolerance edge: residual 2 holds ready, residual 3 drops it
      slew = 12'd5; vin0 = 12'd1797;
      step();
      chk("tol2_vout", vout0, 1795);
      chk("tol2_ready", ready, 2'b01);
      vin0 = 12'd1787;
      step();
      chk("tol3_vout", vout0, 1790);
      chk("tol3_ready", ready, 0);

      // disable mid-slew at 400
      en = 2'b00;
      step();
      chk("dis_vout", vout0, 0);
      en = 2'b01; vin0 = 12'd1000; slew = 12'd100;
      repeat (5) step();
      chk("pre_dis_vout", vout0, 400);
      en = 2'b00;
      step();
      chk("dis2_vout", vout0, 0);
      chk("dis2_ready", ready, 0);

      // reset with a partly filled settle counter
      en = 2'b01; vin0 = 12'd400;
      repeat (6) step();
      chk("pre_rst_vout", vout0, 400);
      chk("pre_rst_ready", ready, 0);
      rst_n = 1'b0;
      step();
      chk("midrst_vout", vout0, 0);
      chk("midrst_ready", ready, 0);
      rst_n = 1'b1; vin0 = 12'd0; slew = 12'd0;
      step();
      repeat (3) step();
      chk("cnt_restart_3", ready, 0);
      step();
      chk("cnt_restart_4", ready, 2'b01);

      // sine on ch1 (tracks vin1 in the default build)
      en = 2'b10; mode = 2'b10; vin1 = 12'd700; freq = 16'd256; slew = 12'd0;
      step();
      chk("sine_entry", vout1, 0);
      chk("sine_ch0_off", vout0, 0);
      repeat (64) step();
      chk("sine_k64", vout1, EXP_K64);
      repeat (128) step();
      chk("sine_k192", vout1, EXP_K192);
      repeat (64) step();
      chk("sine_k0", vout1, EXP_K0);
      chk("sine_sat", sat, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
